axi_lite_read_arbiter: RTL and testbench
========================================

AXI_LITE_READ_ARBITER -- requirements
Module: axi_lite_read_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning the address width on all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the read data width.
REQ-003 SHALL have parameter RESP_WIDTH, default 2, meaning the AXI response width.
REQ-004 SHALL have parameter PROT_WIDTH, default 3, meaning the ARPROT width.
REQ-005 SHALL have port aclk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port arestn, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have ports req0_valid/req1_valid, input, 1 bit each: requester 0 (instruction fetch) and requester 1 (data load) read request.
REQ-008 SHALL have ports req0_addr/req1_addr, input, ADDR_WIDTH each: request address.
REQ-009 SHALL have ports req0_ready/req1_ready, output, 1 bit each: request accepted.
REQ-010 SHALL have ports rsp0_valid/rsp1_valid, output, 1 bit each: one-cycle response pulse.
REQ-011 SHALL have ports rsp_data (output, DATA_WIDTH) and rsp_resp (output, RESP_WIDTH), shared by both requesters.
REQ-012 SHALL have ports m_axi_arready (input), m_axi_arvalid (output), m_axi_araddr (output, ADDR_WIDTH) and m_axi_arprot (output, PROT_WIDTH).
REQ-013 SHALL have ports m_axi_rready (output), m_axi_rvalid (input), m_axi_rdata (input, DATA_WIDTH) and m_axi_rresp (input, RESP_WIDTH): an AXI-Lite read master.

Function
REQ-014 SHALL implement FSM states IDLE, AR and R, with at most one outstanding AXI transaction.
REQ-015 IDLE behaviour: when either reqN_valid=1, SHALL assert reqN_ready combinationally for the winner only, latch its address and port id, and go to AR next cycle.
REQ-016 Arbitration SHALL be round-robin with a last_grant register: if both requests are valid, the port not granted last wins; if only one is valid, that port wins.
REQ-017 last_grant SHALL update only on a grant.
REQ-018 reqN_ready SHALL be 0 outside IDLE; a requester SHALL hold valid/addr stable until ready.
REQ-019 AR state: m_axi_arvalid SHALL be 1 and m_axi_araddr/m_axi_arprot registered and stable until m_axi_arready=1, then the FSM SHALL go to R.
REQ-020 m_axi_arprot SHALL be 3'b100 (instruction) for port 0 and 3'b000 for port 1.
REQ-021 R state: m_axi_rready SHALL be 1; on m_axi_rvalid=1 the block SHALL register rdata/rresp into rsp_data/rsp_resp, pulse rspN_valid of the granted port on the next cycle for exactly 1 cycle, and return to IDLE.
REQ-022 In the cycle rspN_valid=1 the FSM SHALL already be in IDLE and SHALL be able to grant a new request.
REQ-023 Minimum latency: request accepted in cycle N, arvalid in N+1; with arready in N+1 and rvalid in N+2, rspN_valid is in N+3.
REQ-024 rsp_data/rsp_resp SHALL hold their value until the next R handshake.
REQ-025 m_axi_arvalid SHALL be 0 in IDLE and R; m_axi_rready SHALL be 0 in IDLE and AR.
REQ-026 A request arriving during AR or R SHALL wait, unacknowledged, without being dropped.
REQ-027 Non-OKAY rresp SHALL be forwarded unchanged; the block SHALL NOT retry.

Reset
REQ-028 When arestn=0 at a rising edge: state=IDLE, last_grant=1 (so port 0 wins the first tie), m_axi_arvalid=0, m_axi_rready=0, rsp0_valid=rsp1_valid=0, rsp_data=0, rsp_resp=0, latched address=0.
REQ-029 Reset mid-transaction SHALL abandon the transaction and produce no response pulse; the interconnect is reset concurrently.

Verification
REQ-030 Single read: req0_valid with addr 0x0000_0100, arready=1, rvalid next cycle with rdata 0xDEAD_BEEF, rresp 0 -> araddr 0x100, arprot 3'b100, rsp0_valid 1 cycle with rsp_data 0xDEAD_BEEF, rsp1_valid=0.
REQ-031 Tie after reset: req0 (0x10) and req1 (0x20) both held valid -> grants 0x10 (port 0), then 0x20 (port 1, arprot 0), then port 0 again; strict alternation.
REQ-032 Backpressure: arready held 0 for 5 cycles -> arvalid=1 and araddr stable for all 5 cycles, no reqN_ready, response delivered after arready.
REQ-033 Error passthrough: rresp=2'b10 on a port 1 read -> rsp1_valid with rsp_resp=2'b10, no second AR issued.
REQ-034 Reset during R: arestn=0 while waiting for rvalid -> next cycle state IDLE, rready=0, and no rspN_valid in any later cycle for that transaction.
REQ-035 Back-to-back: req1 held valid continuously -> new grant in the same cycle as the rsp1_valid pulse, with exactly one AR per accepted request.

Source files
------------

// File: rtl/axi_lite_read_arbiter.sv
// Two-port AXI-Lite read arbiter: port 0 (instruction fetch) and port 1
// (data load) share a single AXI-Lite read master with one transaction in
// flight. Ties are broken round-robin; responses come back as a one-cycle
// pulse on the granted port with shared data/response lines.
module axi_lite_read_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RESP_WIDTH = 2,
  parameter int PROT_WIDTH = 3
) (
  input  logic                  aclk,
  input  logic                  arestn,
  // requesters
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  output logic                  req1_ready,
  output logic                  rsp0_valid,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [RESP_WIDTH-1:0] rsp_resp,
  // AXI-Lite read master
  input  logic                  m_axi_arready,
  output logic                  m_axi_arvalid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [PROT_WIDTH-1:0] m_axi_arprot,
  output logic                  m_axi_rready,
  input  logic                  m_axi_rvalid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [RESP_WIDTH-1:0] m_axi_rresp
);

  // Instruction fetches are flagged via the instruction bit of ARPROT.
  localparam logic [PROT_WIDTH-1:0] PROT_INSTR = PROT_WIDTH'(4);
  localparam logic [PROT_WIDTH-1:0] PROT_DATA  = '0;

  typedef enum logic [1:0] {IDLE, AR, R} state_t;

  state_t state;
  logic   last_grant;  // port granted most recently
  logic   port_q;      // port owning the transaction in flight
  logic   winner;
  logic   grant;

  // Round-robin pick: on a tie the port not granted last wins.
  always_comb begin
    winner = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    grant  = (state == IDLE) && (req0_valid || req1_valid);
  end

  assign req0_ready = grant && !winner;
  assign req1_ready = grant &&  winner;

  // Transaction FSM; every AXI and response output is a register.
  always_ff @(posedge aclk) begin
    if (!arestn) begin
      state         <= IDLE;
      last_grant    <= 1'b1;  // port 0 wins the first tie
      port_q        <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arprot  <= '0;
      m_axi_rready  <= 1'b0;
      rsp0_valid    <= 1'b0;
      rsp1_valid    <= 1'b0;
      rsp_data      <= '0;
      rsp_resp      <= '0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            port_q        <= winner;
            last_grant    <= winner;
            m_axi_araddr  <= winner ? req1_addr : req0_addr;
            m_axi_arprot  <= winner ? PROT_DATA : PROT_INSTR;
            m_axi_arvalid <= 1'b1;
            state         <= AR;
          end
        end
        AR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= R;
          end
        end
        R: begin
          if (m_axi_rvalid) begin
            // Error responses pass through untouched; no retry.
            m_axi_rready <= 1'b0;
            rsp_data     <= m_axi_rdata;
            rsp_resp     <= m_axi_rresp;
            rsp0_valid   <= !port_q;
            rsp1_valid   <=  port_q;
            state        <= IDLE;
          end
        end
        default: begin
          m_axi_arvalid <= 1'b0;
          m_axi_rready  <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_read_arbiter.sv
// Bench for axi_lite_read_arbiter: transaction-level model checked every
// cycle on the falling edge, a configurable AXI-Lite slave, and directed
// scenarios with literal expectations on grant order, AR traffic and
// response timing.
module tb_axi_lite_read_arbiter;

  logic        aclk = 1'b0;
  logic        arestn = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_addr = '0, req1_addr = '0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic        m_axi_arready = 1'b0, m_axi_arvalid;
  logic [31:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_rready, m_axi_rvalid = 1'b0;
  logic [31:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = '0;

  always #5 aclk = ~aclk;

  axi_lite_read_arbiter dut (
    .aclk(aclk), .arestn(arestn),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_data(rsp_data), .rsp_resp(rsp_resp),
    .m_axi_arready(m_axi_arready), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_rready(m_axi_rready), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp)
  );

  int n_checks = 0, n_fail = 0, cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit pick(input bit r0, input bit r1, input bit last);
    if (r0 && r1) return !last;
    return r1;
  endfunction

  // ---------------- slave ----------------
  int          ar_delay = 0, r_delay = 0, ar_cnt = 0, r_cnt = 0;
  bit          force_data = 1'b0;
  logic [31:0] fdata = '0, cap_addr = '0;
  logic [1:0]  fresp = '0;

  initial forever begin
    @(posedge aclk); #1;
    if (m_axi_arvalid) begin
      cap_addr = m_axi_araddr;
      if (ar_cnt == ar_delay) m_axi_arready = 1'b1;
      else begin m_axi_arready = 1'b0; ar_cnt++; end
    end else begin
      m_axi_arready = 1'b0; ar_cnt = 0;
    end
    if (m_axi_rready) begin
      if (r_cnt == r_delay) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = force_data ? fdata : (cap_addr ^ 32'h5A5A_0000);
        m_axi_rresp  = fresp;
      end else begin
        m_axi_rvalid = 1'b0; r_cnt++;
      end
    end else begin
      m_axi_rvalid = 1'b0; r_cnt = 0;
    end
  end

  // ---------------- model + logs ----------------
  bit          m_busy = 0, m_ar_done = 0, m_port = 0, m_last = 1;
  bit          m_rsp_pend = 0, m_rsp_port = 0;
  logic [31:0] m_addr = '0, m_rsp_data = '0;
  logic [1:0]  m_rsp_resp = '0;

  int          grant_cyc[$], rsp_cyc[$];
  bit          grant_port[$], rsp_port[$];
  logic [31:0] grant_addr[$], ar_addr[$], rsp_dat[$];
  logic [2:0]  ar_prot[$];
  logic [1:0]  rsp_rsp[$];
  int          arv_cycles = 0;

  always @(negedge aclk) begin
    bit w, g;
    cyc++;
    w = pick(req0_valid, req1_valid, m_last);
    g = !m_busy && (req0_valid || req1_valid);
    chk("req0_ready", req0_ready, g && !w);
    chk("req1_ready", req1_ready, g && w);
    chk("arvalid", m_axi_arvalid, m_busy && !m_ar_done);
    chk("rready", m_axi_rready, m_busy && m_ar_done);
    if (m_busy && !m_ar_done) begin
      chk("araddr", m_axi_araddr, m_addr);
      chk("arprot", m_axi_arprot, m_port ? 3'b000 : 3'b100);
    end
    chk("rsp0_valid", rsp0_valid, m_rsp_pend && !m_rsp_port);
    chk("rsp1_valid", rsp1_valid, m_rsp_pend && m_rsp_port);
    chk("rsp_data", rsp_data, m_rsp_data);
    chk("rsp_resp", rsp_resp, m_rsp_resp);

    // observed-event logs for the directed literal checks
    if (arestn) begin
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        grant_cyc.push_back(cyc);
        grant_port.push_back(req1_ready);
        grant_addr.push_back(req1_ready ? req1_addr : req0_addr);
      end
      if (m_axi_arvalid && m_axi_arready) begin
        ar_addr.push_back(m_axi_araddr);
        ar_prot.push_back(m_axi_arprot);
      end
      if (m_axi_arvalid) arv_cycles++;
    end
    if (rsp0_valid || rsp1_valid) begin
      rsp_cyc.push_back(cyc);
      rsp_port.push_back(rsp1_valid);
      rsp_dat.push_back(rsp_data);
      rsp_rsp.push_back(rsp_resp);
    end

    // advance the model by the handshakes that happen at the next edge
    if (!arestn) begin
      m_busy = 0; m_ar_done = 0; m_port = 0; m_last = 1; m_rsp_pend = 0;
      m_addr = '0; m_rsp_data = '0; m_rsp_resp = '0;
    end else begin
      m_rsp_pend = 0;
      if (m_busy && !m_ar_done && m_axi_arready) m_ar_done = 1;
      else if (m_busy && m_ar_done && m_axi_rvalid) begin
        m_busy = 0; m_rsp_pend = 1; m_rsp_port = m_port;
        m_rsp_data = m_axi_rdata; m_rsp_resp = m_axi_rresp;
      end
      if (g) begin
        m_port = w; m_last = w; m_addr = w ? req1_addr : req0_addr;
        m_busy = 1; m_ar_done = 0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge aclk); #1;
  endtask

  task automatic apply_reset();
    arestn = 1'b0; tick(); arestn = 1'b1;
  endtask

  task automatic clear_logs();
    grant_cyc.delete(); grant_port.delete(); grant_addr.delete();
    ar_addr.delete(); ar_prot.delete();
    rsp_cyc.delete(); rsp_port.delete(); rsp_dat.delete(); rsp_rsp.delete();
    arv_cycles = 0;
  endtask

  task automatic req(input bit p, input logic [31:0] a);
    bit got = 0;
    if (p) begin req1_valid = 1; req1_addr = a; end
    else   begin req0_valid = 1; req0_addr = a; end
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge aclk);
      got = p ? req1_ready : req0_ready;
    end
    if (!got) chk("req_timeout", 0, 1);
    tick();
    if (p) req1_valid = 0; else req0_valid = 0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (!m_busy && !m_rsp_pend && !req0_valid && !req1_valid) break;
      tick();
    end
    if (i == budget) chk("idle_timeout", 0, 1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout @%0t", $time);
    $fatal(1, "timeout");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    // reset state
    repeat (3) tick();
    @(negedge aclk);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_rready", m_axi_rready, 0);
    chk("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_resp", rsp_resp, 0);
    tick();
    arestn = 1'b1;
    tick();

    // single read on port 0, minimum latency
    clear_logs();
    force_data = 1; fdata = 32'hDEAD_BEEF; fresp = 2'b00;
    req(0, 32'h0000_0100);
    wait_idle(30);
    chk("single_ar_count", ar_addr.size(), 1);
    chk("single_rsp_count", rsp_port.size(), 1);
    if (ar_addr.size() == 1 && rsp_port.size() == 1 && grant_cyc.size() == 1) begin
      chk("single_araddr", ar_addr[0], 32'h100);
      chk("single_arprot", ar_prot[0], 3'b100);
      chk("single_rsp_port", rsp_port[0], 0);
      chk("single_rsp_data", rsp_dat[0], 32'hDEAD_BEEF);
      chk("single_latency", rsp_cyc[0] - grant_cyc[0], 3);
    end
    chk("single_arv_cycles", arv_cycles, 1);

    // tie after reset: strict alternation starting with port 0
    apply_reset();
    clear_logs();
    force_data = 0;
    req0_valid = 1; req0_addr = 32'h10;
    req1_valid = 1; req1_addr = 32'h20;
    for (int i = 0; i < 100 && grant_port.size() < 4; i++) tick();
    req0_valid = 0; req1_valid = 0;
    wait_idle(30);
    chk("tie_grants", grant_port.size(), 4);
    chk("tie_ars", ar_addr.size(), 4);
    chk("tie_rsps", rsp_port.size(), 4);
    if (grant_port.size() == 4 && ar_addr.size() == 4 && rsp_port.size() == 4) begin
      chk("tie_order", {grant_port[0], grant_port[1], grant_port[2], grant_port[3]}, 4'b0101);
      chk("tie_addr0", ar_addr[0], 32'h10);
      chk("tie_addr1", ar_addr[1], 32'h20);
      chk("tie_prot", {ar_prot[0], ar_prot[1], ar_prot[2], ar_prot[3]}, 12'b100_000_100_000);
      chk("tie_rsp_order", {rsp_port[0], rsp_port[1], rsp_port[2], rsp_port[3]}, 4'b0101);
      chk("tie_rsp_data1", rsp_dat[1], 32'h5A5A_0020);
    end

    // AR backpressure on port 1 while port 0 waits
    clear_logs();
    ar_delay = 5;
    req(1, 32'h300);
    req(0, 32'h400);
    wait_idle(80);
    ar_delay = 0;
    chk("bp_arv_cycles", arv_cycles, 12);
    chk("bp_grants", grant_port.size(), 2);
    if (grant_port.size() == 2 && ar_addr.size() == 2 && rsp_port.size() == 2) begin
      chk("bp_order", {grant_port[0], grant_port[1]}, 2'b10);
      chk("bp_gap", grant_cyc[1] - grant_cyc[0], 8);
      chk("bp_addr0", ar_addr[0], 32'h300);
      chk("bp_addr1", ar_addr[1], 32'h400);
      chk("bp_rsp_data0", rsp_dat[0], 32'h5A5A_0300);
    end

    // error response forwarded, no retry
    clear_logs();
    force_data = 1; fdata = 32'h1234_5678; fresp = 2'b10;
    req(1, 32'h40);
    wait_idle(30);
    repeat (5) tick();
    fresp = 2'b00; force_data = 0;
    chk("err_ar_count", ar_addr.size(), 1);
    chk("err_rsp_count", rsp_port.size(), 1);
    if (rsp_port.size() == 1) begin
      chk("err_rsp_port", rsp_port[0], 1);
      chk("err_rsp_resp", rsp_rsp[0], 2'b10);
      chk("err_rsp_data", rsp_dat[0], 32'h1234_5678);
    end

    // reset while waiting for rvalid
    clear_logs();
    r_delay = 100;
    req(0, 32'h50);
    begin
      bit seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
        @(negedge aclk); seen = m_axi_rready;
      end
      chk("rr_reached_R", seen, 1);
    end
    tick(); tick();
    apply_reset();
    @(negedge aclk);
    chk("rr_rready_after_reset", m_axi_rready, 0);
    chk("rr_arvalid_after_reset", m_axi_arvalid, 0);
    repeat (10) tick();
    r_delay = 0;
    chk("rr_no_rsp", rsp_port.size(), 0);

    // back-to-back on port 1
    clear_logs();
    req1_valid = 1; req1_addr = 32'h60;
    for (int i = 0; i < 100 && grant_port.size() < 3; i++) tick();
    req1_valid = 0;
    wait_idle(30);
    chk("b2b_grants", grant_port.size(), 3);
    chk("b2b_ars", ar_addr.size(), 3);
    chk("b2b_rsps", rsp_port.size(), 3);
    if (grant_cyc.size() == 3 && rsp_cyc.size() == 3) begin
      chk("b2b_same_cycle0", grant_cyc[1], rsp_cyc[0]);
      chk("b2b_same_cycle1", grant_cyc[2], rsp_cyc[1]);
      chk("b2b_ports", {rsp_port[0], rsp_port[1], rsp_port[2]}, 3'b111);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
